// File: rtl/l2_request_arbiter_pkg.sv
// Shared L2 request definitions: op codes, field widths and the request payload.
package l2_request_arbiter_pkg;

    localparam int unsigned CORE_ID_W = 2;
    localparam int unsigned UNIT_W    = 2;
    localparam int unsigned STRAND_W  = 2;
    localparam int unsigned WAY_W     = 2;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned ADDR_W    = 26;
    localparam int unsigned DATA_W    = 512;
    localparam int unsigned MASK_W    = 64;

    typedef enum logic [OP_W-1:0] {
        L2REQ_LOAD        = 3'd0,
        L2REQ_STORE       = 3'd1,
        L2REQ_FLUSH       = 3'd2,
        L2REQ_DINVALIDATE = 3'd3,
        L2REQ_IINVALIDATE = 3'd4,
        L2REQ_LOAD_SYNC   = 3'd5,
        L2REQ_STORE_SYNC  = 3'd6,
        L2REQ_MEMBAR      = 3'd7
    } l2req_op_t;

    typedef struct packed {
        logic [CORE_ID_W-1:0] core;
        logic [UNIT_W-1:0]    unit;
        logic [STRAND_W-1:0]  strand;
        logic [OP_W-1:0]      op;
        logic [WAY_W-1:0]     way;
        logic [ADDR_W-1:0]    address;
        logic [DATA_W-1:0]    data;
        logic [MASK_W-1:0]    mask;
    } l2_request_t;

endpackage

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module l2_request_arbiter_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_index,
    output logic             grant_valid
);

    int               sum;
    logic [IDX_W-1:0] idx;

    // Scan offsets from farthest to nearest so the closest requester to ptr wins.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        sum         = 0;
        idx         = '0;
        if (enable) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                sum = int'(ptr) + i;
                idx = IDX_W'(sum % int'(N));
                if (request[idx]) begin
                    grant       = '0;
                    grant[idx]  = 1'b1;
                    grant_index = idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// L2 pipeline front end: picks a restart or core request each unstalled cycle and registers it.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES    = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall_pipeline,
    input  logic [NUM_CORES-1:0]          pci_valid,
    output logic [NUM_CORES-1:0]          pci_ack,
    input  logic [UNIT_W*NUM_CORES-1:0]   pci_unit,
    input  logic [STRAND_W*NUM_CORES-1:0] pci_strand,
    input  logic [OP_W*NUM_CORES-1:0]     pci_op,
    input  logic [WAY_W*NUM_CORES-1:0]    pci_way,
    input  logic [ADDR_W*NUM_CORES-1:0]   pci_address,
    input  logic [DATA_W*NUM_CORES-1:0]   pci_data,
    input  logic [MASK_W*NUM_CORES-1:0]   pci_mask,
    input  logic                          restart_valid,
    output logic                          restart_ack,
    input  logic [CORE_ID_W-1:0]          restart_core,
    input  logic [UNIT_W-1:0]             restart_unit,
    input  logic [STRAND_W-1:0]           restart_strand,
    input  logic [WAY_W-1:0]              restart_way,
    input  logic [OP_W-1:0]               restart_op,
    input  logic [ADDR_W-1:0]             restart_address,
    input  logic [DATA_W-1:0]             restart_data,
    input  logic [MASK_W-1:0]             restart_mask,
    input  logic [DATA_W-1:0]             restart_sm_data,
    input  logic [WAY_W-1:0]              restart_sm_fill_way,
    output logic                          arb_l2req_valid,
    output logic [CORE_ID_W-1:0]          arb_l2req_core,
    output logic [UNIT_W-1:0]             arb_l2req_unit,
    output logic [STRAND_W-1:0]           arb_l2req_strand,
    output logic [WAY_W-1:0]              arb_l2req_way,
    output logic [OP_W-1:0]               arb_l2req_op,
    output logic [ADDR_W-1:0]             arb_l2req_address,
    output logic [DATA_W-1:0]             arb_l2req_data,
    output logic [MASK_W-1:0]             arb_l2req_mask,
    output logic                          arb_has_sm_data,
    output logic [DATA_W-1:0]             arb_sm_data,
    output logic [WAY_W-1:0]              arb_sm_fill_way
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [IDX_W-1:0] LAST_CORE  = IDX_W'(NUM_CORES - 1);

    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] starve_count;
    logic             any_core;
    logic             arb_enable;
    logic             grant_restart;
    logic             core_enable;
    logic [NUM_CORES-1:0] core_grant;
    logic [IDX_W-1:0] core_index;
    logic             core_grant_valid;
    l2_request_t      core_req [NUM_CORES];
    l2_request_t      restart_req;
    l2_request_t      arb_req;

    // Unpack the flat per-core buses into request payloads.
    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        assign core_req[c] = '{
            core:    CORE_ID_W'(c),
            unit:    pci_unit[c*UNIT_W +: UNIT_W],
            strand:  pci_strand[c*STRAND_W +: STRAND_W],
            op:      pci_op[c*OP_W +: OP_W],
            way:     pci_way[c*WAY_W +: WAY_W],
            address: pci_address[c*ADDR_W +: ADDR_W],
            data:    pci_data[c*DATA_W +: DATA_W],
            mask:    pci_mask[c*MASK_W +: MASK_W]
        };
    end

    assign restart_req = '{
        core:    restart_core,
        unit:    restart_unit,
        strand:  restart_strand,
        op:      restart_op,
        way:     restart_way,
        address: restart_address,
        data:    restart_data,
        mask:    restart_mask
    };

    // Restarts win unless cores have been starved for STARVE_LIMIT grants.
    assign any_core      = |pci_valid;
    assign arb_enable    = reset_n & ~stall_pipeline;
    assign grant_restart = arb_enable & restart_valid
                         & ((starve_count < STARVE_MAX) | ~any_core);
    assign core_enable   = arb_enable & ~grant_restart;

    l2_request_arbiter_rr_arbiter #(.N(NUM_CORES)) u_rr_arbiter (
        .request     (pci_valid),
        .ptr         (rr_ptr),
        .enable      (core_enable),
        .grant       (core_grant),
        .grant_index (core_index),
        .grant_valid (core_grant_valid)
    );

    assign pci_ack     = core_grant;
    assign restart_ack = grant_restart;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            arb_l2req_valid <= 1'b0;
            arb_req         <= '0;
            arb_has_sm_data <= 1'b0;
            arb_sm_data     <= '0;
            arb_sm_fill_way <= '0;
            rr_ptr          <= '0;
            starve_count    <= '0;
        end else if (!stall_pipeline) begin
            if (grant_restart) begin
                arb_l2req_valid <= 1'b1;
                arb_req         <= restart_req;
                arb_has_sm_data <= 1'b1;
                arb_sm_data     <= restart_sm_data;
                arb_sm_fill_way <= restart_sm_fill_way;
                if (!any_core) begin
                    starve_count <= '0;
                end else if (starve_count != STARVE_MAX) begin
                    starve_count <= starve_count + CNT_W'(1);
                end
            end else if (core_grant_valid) begin
                arb_l2req_valid <= 1'b1;
                arb_req         <= core_req[core_index];
                arb_has_sm_data <= 1'b0;
                arb_sm_data     <= '0;
                arb_sm_fill_way <= '0;
                rr_ptr          <= (core_index == LAST_CORE) ? '0 : core_index + IDX_W'(1);
                starve_count    <= '0;
            end else begin
                arb_l2req_valid <= 1'b0;
                starve_count    <= '0;
            end
        end
    end

    assign arb_l2req_core    = arb_req.core;
    assign arb_l2req_unit    = arb_req.unit;
    assign arb_l2req_strand  = arb_req.strand;
    assign arb_l2req_way     = arb_req.way;
    assign arb_l2req_op      = arb_req.op;
    assign arb_l2req_address = arb_req.address;
    assign arb_l2req_data    = arb_req.data;
    assign arb_l2req_mask    = arb_req.mask;

endmodule
